param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/param_sync_fifo.sv | 122 ++++++++++++
 tb/tb_param_sync_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with occupancy-derived status flags and sticky over/underflow.
// FWFT selects a registered read port or a head-of-queue (fall-through) read port.
module param_sync_fifo #(
   parameter int WIDTH     = 4,
   parameter int DEPTH     = 8,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2,
   parameter bit FWFT      = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   wr_rq,
   input  logic                   rd_rq,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic                   almost_full,
   output logic                   almost_empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

   generate
      if (WIDTH < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
          AF_THRESH > DEPTH || AE_THRESH >= DEPTH) begin : g_bad_cfg
         $error("param_sync_fifo: illegal WIDTH/DEPTH/threshold configuration");
      end
   endgenerate

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             rd_acc, wr_acc;
   logic             wr_en, rd_en;

   assign full         = (count_q == DEPTH_C);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AF_C);
   assign almost_empty = (count_q <= AE_C);
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

   // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
   assign rd_acc = rd_rq && !empty;
   assign wr_acc = wr_rq && (!full || rd_acc);
   assign wr_en  = wr_acc && !flush;
   assign rd_en  = rd_acc && !flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         unf_d    = 1'b0;
      end else begin
         if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
         if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
         case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
         if (wr_rq && !wr_acc) ovf_d = 1'b1;
         if (rd_rq && empty)   unf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Storage is deliberately left out of reset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= wdata;
   end

   generate
      if (FWFT) begin : g_fwft
         // Forced to zero while empty so reset shows a clean rdata without resetting memory.
         assign rdata = empty ? '0 : mem_q[rd_ptr_q];
      end else begin : g_std
         logic [WIDTH-1:0] rdata_q;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)       rdata_q <= '0;
            else if (rd_en) rdata_q <= mem_q[rd_ptr_q];
         end
         assign rdata = rdata_q;
      end
   endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed and randomized checks of param_sync_fifo in both read modes, driven with identical stimulus.
module tb_param_sync_fifo;

   logic       clk;
   logic       rst;
   logic       flush, wr_rq, rd_rq;
   logic [3:0] wdata;

   logic [3:0] rdata0, rdata1;
   logic       full0, empty0, af0, ae0, ov0, un0;
   logic       full1, empty1, af1, ae1, ov1, un1;
   logic [3:0] count0, count1;

   int errors = 0;
   int checks = 0;

   param_sync_fifo #(.WIDTH(4), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .flush(flush), .wr_rq(wr_rq), .rd_rq(rd_rq), .wdata(wdata),
      .rdata(rdata0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
      .count(count0), .overflow(ov0), .underflow(un0));

   param_sync_fifo #(.WIDTH(4), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b1)) u_dut1 (
      .clk(clk), .rst(rst), .flush(flush), .wr_rq(wr_rq), .rd_rq(rd_rq), .wdata(wdata),
      .rdata(rdata1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
      .count(count1), .overflow(ov1), .underflow(un1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       wr, rd, fl;
      logic [3:0] wd;
      int         cnt;
      logic       full, empty, af, ae, ov, un;
      logic [3:0] rd0;
      logic       rd1_v;
      logic [3:0] rd1;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(logic wr, logic rd, logic fl, logic [3:0] wd, int cnt,
                               logic f, logic e, logic a_f, logic a_e, logic o, logic u,
                               logic [3:0] r0, logic r1v, logic [3:0] r1);
      vec_t v;
      v.wr = wr; v.rd = rd; v.fl = fl; v.wd = wd; v.cnt = cnt;
      v.full = f; v.empty = e; v.af = a_f; v.ae = a_e; v.ov = o; v.un = u;
      v.rd0 = r0; v.rd1_v = r1v; v.rd1 = r1;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
      end
   endtask

   task automatic step(input logic wr, input logic rd, input logic fl, input logic [3:0] wd);
      wr_rq = wr; rd_rq = rd; flush = fl; wdata = wd;
      @(posedge clk);
      #1;
      wr_rq = 1'b0; rd_rq = 1'b0; flush = 1'b0;
   endtask

   task automatic chk_status(input string tag, input int cnt, input logic f, input logic e,
                             input logic a_f, input logic a_e, input logic o, input logic u);
      chk({tag, " count0"}, int'(count0), cnt);
      chk({tag, " count1"}, int'(count1), cnt);
      chk({tag, " full"},   int'({full0, full1}),   int'({f, f}));
      chk({tag, " empty"},  int'({empty0, empty1}), int'({e, e}));
      chk({tag, " afull"},  int'({af0, af1}),       int'({a_f, a_f}));
      chk({tag, " aempty"}, int'({ae0, ae1}),       int'({a_e, a_e}));
      chk({tag, " ovf"},    int'({ov0, ov1}),       int'({o, o}));
      chk({tag, " unf"},    int'({un0, un1}),       int'({u, u}));
   endtask

   logic [3:0] m_rd0;
   logic [3:0] q[$];
   int         mwp, mrp, wraps;
   logic       m_ov, m_un;

   initial begin
      rst = 1'b1; flush = 1'b0; wr_rq = 1'b0; rd_rq = 1'b0; wdata = '0;
      #2 rst = 1'b0;
      #2;
      chk_status("reset", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("reset rdata0", int'(rdata0), 0);
      @(negedge clk);
      #2 rst = 1'b1;

      //           wr rd fl wd   | cnt  f  e  af ae ov un  rd0 r1v rd1
      vt.push_back(mk(1, 0, 0, 4'h1, 1, 0, 0, 0, 1, 0, 0, 4'h0, 1, 4'h1));
      vt.push_back(mk(1, 0, 0, 4'h2, 2, 0, 0, 0, 1, 0, 0, 4'h0, 1, 4'h1));
      vt.push_back(mk(1, 0, 0, 4'h3, 3, 0, 0, 0, 0, 0, 0, 4'h0, 1, 4'h1));
      vt.push_back(mk(1, 0, 0, 4'h4, 4, 0, 0, 0, 0, 0, 0, 4'h0, 1, 4'h1));
      vt.push_back(mk(1, 0, 0, 4'h5, 5, 0, 0, 0, 0, 0, 0, 4'h0, 1, 4'h1));
      vt.push_back(mk(1, 0, 0, 4'h6, 6, 0, 0, 1, 0, 0, 0, 4'h0, 1, 4'h1));
      vt.push_back(mk(1, 0, 0, 4'h7, 7, 0, 0, 1, 0, 0, 0, 4'h0, 1, 4'h1));
      vt.push_back(mk(1, 0, 0, 4'h8, 8, 1, 0, 1, 0, 0, 0, 4'h0, 1, 4'h1));
      vt.push_back(mk(1, 0, 0, 4'hF, 8, 1, 0, 1, 0, 1, 0, 4'h0, 1, 4'h1));
      vt.push_back(mk(0, 1, 0, 4'h0, 7, 0, 0, 1, 0, 1, 0, 4'h1, 1, 4'h2));
      vt.push_back(mk(0, 1, 0, 4'h0, 6, 0, 0, 1, 0, 1, 0, 4'h2, 1, 4'h3));
      vt.push_back(mk(0, 1, 0, 4'h0, 5, 0, 0, 0, 0, 1, 0, 4'h3, 1, 4'h4));
      vt.push_back(mk(0, 1, 0, 4'h0, 4, 0, 0, 0, 0, 1, 0, 4'h4, 1, 4'h5));
      vt.push_back(mk(0, 1, 0, 4'h0, 3, 0, 0, 0, 0, 1, 0, 4'h5, 1, 4'h6));
      vt.push_back(mk(0, 1, 0, 4'h0, 2, 0, 0, 0, 1, 1, 0, 4'h6, 1, 4'h7));
      vt.push_back(mk(0, 1, 0, 4'h0, 1, 0, 0, 0, 1, 1, 0, 4'h7, 1, 4'h8));
      vt.push_back(mk(0, 1, 0, 4'h0, 0, 0, 1, 0, 1, 1, 0, 4'h8, 0, 4'h0));
      vt.push_back(mk(0, 1, 0, 4'h0, 0, 0, 1, 0, 1, 1, 1, 4'h8, 0, 4'h0));
      vt.push_back(mk(1, 1, 1, 4'h9, 0, 0, 1, 0, 1, 0, 0, 4'h8, 0, 4'h0));

      foreach (vt[i]) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         step(vt[i].wr, vt[i].rd, vt[i].fl, vt[i].wd);
         chk_status(tag, vt[i].cnt, vt[i].full, vt[i].empty, vt[i].af, vt[i].ae, vt[i].ov, vt[i].un);
         chk({tag, " rdata0"}, int'(rdata0), int'(vt[i].rd0));
         if (vt[i].rd1_v) chk({tag, " rdata1"}, int'(rdata1), int'(vt[i].rd1));
      end
      m_rd0 = 4'h8;

      // Full FIFO with simultaneous read and write.
      for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b0, 4'(i));
      chk_status("sim_full pre", 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 4'h9);
      chk_status("sim_full", 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("sim_full rdata0", int'(rdata0), 1);
      chk("sim_full rdata1", int'(rdata1), 2);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 1'b0, 4'h0);
         chk($sformatf("sim_full drain%0d", i), int'(rdata0), i + 2);
      end
      chk_status("sim_full drained", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      m_rd0 = 4'h9;

      // Empty FIFO with simultaneous read and write.
      step(1'b1, 1'b1, 1'b0, 4'h5);
      chk_status("sim_empty", 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("sim_empty rdata0 held", int'(rdata0), int'(m_rd0));
      chk("sim_empty rdata1", int'(rdata1), 5);
      step(1'b0, 1'b0, 1'b1, 4'h0);
      chk_status("sim_empty flush", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

      // Fall-through visibility of a write into an empty FIFO.
      step(1'b1, 1'b0, 1'b0, 4'hA);
      chk("fwft rdata1", int'(rdata1), 10);
      chk("fwft empty1", int'(empty1), 0);
      step(1'b0, 1'b1, 1'b0, 4'h0);
      chk("fwft empty after rd", int'({empty0, empty1}), 3);
      chk("fwft rdata0", int'(rdata0), 10);
      m_rd0 = 4'hA;
      step(1'b0, 1'b0, 1'b1, 4'h0);

      // Random traffic against a reference queue.
      q = {}; mwp = 0; mrp = 0; wraps = 0; m_ov = 1'b0; m_un = 1'b0;
      for (int c = 0; c < 150; c++) begin
         logic w, r, ra, wa;
         logic [3:0] d;
         w = ($urandom_range(0, 99) < 60);
         r = ($urandom_range(0, 99) < 55);
         d = 4'($urandom_range(0, 15));
         ra = r && (q.size() > 0);
         wa = w && ((q.size() < 8) || ra);
         if (w && !wa) m_ov = 1'b1;
         if (r && q.size() == 0) m_un = 1'b1;
         if (ra) begin
            m_rd0 = q.pop_front();
            if (mrp == 7) wraps++;
            mrp = (mrp + 1) % 8;
         end
         if (wa) begin
            q.push_back(d);
            if (mwp == 7) wraps++;
            mwp = (mwp + 1) % 8;
         end
         step(w, r, 1'b0, d);
         chk($sformatf("rand%0d count", c), int'(count0), q.size());
         chk($sformatf("rand%0d rdata0", c), int'(rdata0), int'(m_rd0));
         if (q.size() > 0) chk($sformatf("rand%0d rdata1", c), int'(rdata1), int'(q[0]));
         chk($sformatf("rand%0d flags", c), int'({ov0, un0, ov1, un1}), int'({m_ov, m_un, m_ov, m_un}));
      end
      checks++;
      if (wraps < 10) begin
         errors++;
         $display("FAIL rand wraps: got %0d pointer wraps, required at least 10", wraps);
      end

      // Asynchronous reset while holding five words.
      step(1'b0, 1'b0, 1'b1, 4'h0);
      for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 1'b0, 4'(i));
      chk("areset pre count", int'(count0), 5);
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
      chk_status("areset", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("areset rdata0", int'(rdata0), 0);
      @(negedge clk);
      #1 rst = 1'b1;
      step(1'b1, 1'b0, 1'b0, 4'hC);
      chk("post_reset count", int'(count0), 1);
      chk("post_reset rdata1", int'(rdata1), 12);
      step(1'b0, 1'b1, 1'b0, 4'h0);
      chk("post_reset rdata0", int'(rdata0), 12);
      chk("post_reset empty", int'(empty0), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
